mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_watchdog.sv | 53 +++++
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the mem_arbiter slice: the arbiter FSM
// state encoding, the transaction owner encoding and the fill value that an
// aborted transaction returns to its requester.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Replicated across DATA_W by the arbiter when a transaction is aborted.
    localparam logic MEM_ARB_ALL_ONES = 1'b1;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Saturating BUSY-cycle counter for mem_arbiter.
// clear_i zeroes the count when a transaction is granted. enable_i is high
// for every BUSY cycle that has no acknowledge. expired_o flags the BUSY
// cycle in which the count reaches TIMEOUT, so the arbiter can abort at the
// end of that cycle. With TIMEOUT = 0 there is no counter and expired_o is 0.
module mem_arbiter_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic unused_wd;
            assign unused_wd = clk ^ rst ^ clear_i ^ enable_i;
            assign expired_o = 1'b0;
        end else begin : g_enabled
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Clear on grant, otherwise count unacknowledged BUSY cycles and hold at the maximum
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (enable_i && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Count register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired_o = enable_i && (cnt_q == CNT_LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Memory-port arbiter for the pipelined mMIPS core.
// Shares one req/ack memory bus between instruction fetch and data memory.
// Only one transaction is in flight at a time. The arbiter returns read data
// and produces the imem_wait/dmem_wait stalls for the hazard unit.
// A watchdog aborts transactions that are never acknowledged. An aborted
// transaction returns all ones and sets the sticky timeout_err flag.
// Build option MEM_ARBITER_RR_EN: when defined, simultaneous requests in IDLE
// alternate round-robin. When undefined, data always beats fetch and no
// last-owner register exists.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  imem_req,
    input  logic [ADDR_W-1:0]     imem_addr,
    output logic [DATA_W-1:0]     imem_rdata,
    output logic                  imem_wait,

    input  logic                  dmem_req,
    input  logic                  dmem_we,
    input  logic [DATA_W/8-1:0]   dmem_be,
    input  logic [ADDR_W-1:0]     dmem_addr,
    input  logic [DATA_W-1:0]     dmem_wdata,
    output logic [DATA_W-1:0]     dmem_rdata,
    output logic                  dmem_wait,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,

    output logic                  timeout_err
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [DATA_W-1:0] ABORT_DATA = {DATA_W{MEM_ARB_ALL_ONES}};

    arb_state_e          state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   imem_rdata_q, imem_rdata_d;
    logic [DATA_W-1:0]   dmem_rdata_q, dmem_rdata_d;
    logic                timeout_err_q, timeout_err_d;

    logic                grant_i;
    logic                grant_d;
    logic                busy;
    logic                wd_clear;
    logic                wd_enable;
    logic                wd_expired;

    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

`ifdef MEM_ARBITER_RR_EN
    owner_e last_owner_q;

    // Remember who received the most recent grant so a tie goes to the other requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWN_I;
        end else if (grant_d) begin
            last_owner_q <= OWN_D;
        end else if (grant_i) begin
            last_owner_q <= OWN_I;
        end
    end
`endif

    // Grant decision: arbitrate in IDLE; in DONE only the other requester may be granted
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef MEM_ARBITER_RR_EN
                if (imem_req && dmem_req) begin
                    if (last_owner_q == OWN_I) begin
                        grant_d = 1'b1;
                    end else begin
                        grant_i = 1'b1;
                    end
                end else begin
                    grant_d = dmem_req;
                    grant_i = imem_req;
                end
`else
                grant_d = dmem_req;
                grant_i = imem_req & ~dmem_req;
`endif
            end
            DONE_I:  grant_d = dmem_req;
            DONE_D:  grant_i = imem_req;
            default: begin
                grant_i = 1'b0;
                grant_d = 1'b0;
            end
        endcase
    end

    // Next state, bus register loads on grant, read data capture and abort handling
    always_comb begin
        state_d       = state_q;
        mem_we_d      = mem_we_q;
        mem_be_d      = mem_be_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        imem_rdata_d  = imem_rdata_q;
        dmem_rdata_d  = dmem_rdata_q;
        timeout_err_d = timeout_err_q;

        if (grant_d) begin
            state_d     = BUSY_D;
            mem_addr_d  = dmem_addr;
            mem_we_d    = dmem_we;
            mem_be_d    = dmem_be;
            mem_wdata_d = dmem_wdata;
        end else if (grant_i) begin
            state_d    = BUSY_I;
            mem_addr_d = imem_addr;
            mem_we_d   = 1'b0;
            mem_be_d   = '1;
        end else begin
            case (state_q)
                BUSY_I: begin
                    if (mem_ack) begin
                        imem_rdata_d = mem_rdata;
                        state_d      = DONE_I;
                    end else if (wd_expired) begin
                        imem_rdata_d  = ABORT_DATA;
                        timeout_err_d = 1'b1;
                        state_d       = DONE_I;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        if (!mem_we_q) begin
                            dmem_rdata_d = mem_rdata;
                        end
                        state_d = DONE_D;
                    end else if (wd_expired) begin
                        dmem_rdata_d  = ABORT_DATA;
                        timeout_err_d = 1'b1;
                        state_d       = DONE_D;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_we_q      <= 1'b0;
            mem_be_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            imem_rdata_q  <= '0;
            dmem_rdata_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_we_q      <= mem_we_d;
            mem_be_q      <= mem_be_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            imem_rdata_q  <= imem_rdata_d;
            dmem_rdata_q  <= dmem_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign wd_clear  = grant_i | grant_d;
    assign wd_enable = busy & ~mem_ack;

    mem_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    assign mem_req     = busy;
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign imem_rdata  = imem_rdata_q;
    assign dmem_rdata  = dmem_rdata_q;
    assign timeout_err = timeout_err_q;

    assign imem_wait = imem_req & ~(state_q == DONE_I);
    assign dmem_wait = dmem_req & ~(state_q == DONE_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Instance A uses TIMEOUT = 4 and carries
// most scenarios. Instance B uses the default TIMEOUT and shares A's inputs.
// It is observed only in the slow-acknowledge scenario, because A's watchdog
// would abort that transaction.
// Expectations change when compiled with MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        dmemReq;
    logic        dmemWe;
    logic [3:0]  dmemBe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [31:0] memRdata;
    logic        memAck;

    logic [31:0] imemRdataA, dmemRdataA, memAddrA, memWdataA;
    logic        imemWaitA, dmemWaitA, memReqA, memWeA, timeoutErrA;
    logic [3:0]  memBeA;
    logic [31:0] imemRdataB, dmemRdataB, memAddrB, memWdataB;
    logic        imemWaitB, dmemWaitB, memReqB, memWeB, timeoutErrB;
    logic [3:0]  memBeB;

    int testsRun  = 0;
    int failCount = 0;
    bit firstIsData;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) uDutA (
        .clk(clk), .rst(rst),
        .imem_req(imemReq), .imem_addr(imemAddr), .imem_rdata(imemRdataA), .imem_wait(imemWaitA),
        .dmem_req(dmemReq), .dmem_we(dmemWe), .dmem_be(dmemBe), .dmem_addr(dmemAddr),
        .dmem_wdata(dmemWdata), .dmem_rdata(dmemRdataA), .dmem_wait(dmemWaitA),
        .mem_req(memReqA), .mem_we(memWeA), .mem_be(memBeA), .mem_addr(memAddrA),
        .mem_wdata(memWdataA), .mem_rdata(memRdata), .mem_ack(memAck),
        .timeout_err(timeoutErrA)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) uDutB (
        .clk(clk), .rst(rst),
        .imem_req(imemReq), .imem_addr(imemAddr), .imem_rdata(imemRdataB), .imem_wait(imemWaitB),
        .dmem_req(dmemReq), .dmem_we(dmemWe), .dmem_be(dmemBe), .dmem_addr(dmemAddr),
        .dmem_wdata(dmemWdata), .dmem_rdata(dmemRdataB), .dmem_wait(dmemWaitB),
        .mem_req(memReqB), .mem_we(memWeB), .mem_be(memBeB), .mem_addr(memAddrB),
        .mem_wdata(memWdataB), .mem_rdata(memRdata), .mem_ack(memAck),
        .timeout_err(timeoutErrB)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL runaway: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Drive one cycle of inputs at the falling edge, then settle before checks
    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                 input logic dReq, input logic dWe, input logic [3:0] dBe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata,
                                 input logic ack, input logic [31:0] rdata);
        @(negedge clk);
        imemReq   = iReq;
        imemAddr  = iAddr;
        dmemReq   = dReq;
        dmemWe    = dWe;
        dmemBe    = dBe;
        dmemAddr  = dAddr;
        dmemWdata = dWdata;
        memAck    = ack;
        memRdata  = rdata;
        #1;
    endtask

    // Compare a word against its hand-computed value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare a single-bit output against its hand-computed value
    task automatic checkBit(input string tag, input logic observed, input logic expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Idle all inputs and pulse reset for one cycle
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        imemReq = 1'b0; dmemReq = 1'b0; memAck = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Linear sequence of directed scenarios
    initial begin
`ifdef MEM_ARBITER_RR_EN
        firstIsData = 1'b0;
`else
        firstIsData = 1'b1;
`endif
        rst = 1'b1;
        imemReq = 1'b1; imemAddr = '0;
        dmemReq = 1'b0; dmemWe = 1'b0; dmemBe = '0; dmemAddr = '0; dmemWdata = '0;
        memAck = 1'b0; memRdata = '0;
        #3;
        checkBit("rst memReq", memReqA, 1'b0);
        checkBit("rst memWe", memWeA, 1'b0);
        checkOutput("rst memBe", 32'(memBeA), 32'h0);
        checkOutput("rst memAddr", memAddrA, 32'h0);
        checkOutput("rst memWdata", memWdataA, 32'h0);
        checkOutput("rst imemRdata", imemRdataA, 32'h0);
        checkOutput("rst dmemRdata", dmemRdataA, 32'h0);
        checkBit("rst timeoutErr", timeoutErrA, 1'b0);
        checkBit("rst imemWait", imemWaitA, 1'b1);
        imemReq = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Slow memory on instance B: ack in the fifth BUSY cycle
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h500, 0, 0, 0);
        checkBit("slow wait c0", dmemWaitB, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, 1, 0, 4'hF, 32'h500, 0, (i == 5), (i == 5) ? 32'h55AA55AA : 32'h0);
            checkBit("slow memReq busy", memReqB, 1'b1);
            checkBit("slow dmemWait busy", dmemWaitB, 1'b1);
        end
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h500, 0, 0, 0);
        checkBit("slow dmemWait c6", dmemWaitB, 1'b0);
        checkBit("slow memReq c6", memReqB, 1'b0);
        checkOutput("slow dmemRdata", dmemRdataB, 32'h55AA55AA);
        doReset();

        // Zero-wait fetch
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        checkBit("fetch wait c0", imemWaitA, 1'b1);
        checkBit("fetch memReq c0", memReqA, 1'b0);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h2402000A);
        checkBit("fetch memReq c1", memReqA, 1'b1);
        checkOutput("fetch memAddr", memAddrA, 32'h100);
        checkBit("fetch memWe", memWeA, 1'b0);
        checkOutput("fetch memBe", 32'(memBeA), 32'hF);
        checkBit("fetch wait c1", imemWaitA, 1'b1);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        checkBit("fetch wait c2", imemWaitA, 1'b0);
        checkOutput("fetch imemRdata", imemRdataA, 32'h2402000A);
        checkBit("fetch memReq c2", memReqA, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Contention: data write and fetch together, data first, fetch with no IDLE bubble
        applyStimulus(1, 32'h104, 1, 1, 4'hF, 32'h400, 32'hDEADBEEF, 0, 0);
        checkBit("cont1 imemWait c0", imemWaitA, 1'b1);
        checkBit("cont1 dmemWait c0", dmemWaitA, 1'b1);
        applyStimulus(1, 32'h104, 1, 1, 4'hF, 32'h400, 32'hDEADBEEF, 1, 32'h12345678);
        checkBit("cont1 memReq c1", memReqA, 1'b1);
        checkBit("cont1 memWe c1", memWeA, 1'b1);
        checkOutput("cont1 memAddr c1", memAddrA, 32'h400);
        checkOutput("cont1 memWdata c1", memWdataA, 32'hDEADBEEF);
        applyStimulus(1, 32'h104, 1, 1, 4'hF, 32'h400, 32'hDEADBEEF, 0, 0);
        checkBit("cont1 dmemWait c2", dmemWaitA, 1'b0);
        checkBit("cont1 imemWait c2", imemWaitA, 1'b1);
        checkOutput("cont1 write keeps dmemRdata", dmemRdataA, 32'h0);
        applyStimulus(1, 32'h104, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        checkBit("cont1 memReq c3", memReqA, 1'b1);
        checkBit("cont1 memWe c3", memWeA, 1'b0);
        checkOutput("cont1 memAddr c3", memAddrA, 32'h104);
        checkOutput("cont1 memBe c3", 32'(memBeA), 32'hF);
        applyStimulus(1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
        checkBit("cont1 imemWait c4", imemWaitA, 1'b0);
        checkOutput("cont1 imemRdata", imemRdataA, 32'hCAFEF00D);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkBit("cont1 memReq idle", memReqA, 1'b0);

        // Back-to-back data reads from the same requester pass through IDLE
        applyStimulus(0, 0, 1, 0, 4'h3, 32'h408, 0, 0, 0);
        checkBit("rd dmemWait c0", dmemWaitA, 1'b1);
        applyStimulus(0, 0, 1, 0, 4'h3, 32'h408, 0, 1, 32'h0BADF00D);
        checkBit("rd memReq c1", memReqA, 1'b1);
        checkOutput("rd memBe c1", 32'(memBeA), 32'h3);
        checkBit("rd memWe c1", memWeA, 1'b0);
        checkOutput("rd memAddr c1", memAddrA, 32'h408);
        applyStimulus(0, 0, 1, 0, 4'h3, 32'h408, 0, 0, 0);
        checkBit("rd dmemWait c2", dmemWaitA, 1'b0);
        checkOutput("rd dmemRdata 1", dmemRdataA, 32'h0BADF00D);
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h40C, 0, 0, 0);
        checkBit("rd bubble memReq", memReqA, 1'b0);
        checkBit("rd bubble dmemWait", dmemWaitA, 1'b1);
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h40C, 0, 1, 32'h11112222);
        checkBit("rd memReq c4", memReqA, 1'b1);
        checkOutput("rd memAddr c4", memAddrA, 32'h40C);
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h40C, 0, 0, 0);
        checkBit("rd dmemWait c5", dmemWaitA, 1'b0);
        checkOutput("rd dmemRdata 2", dmemRdataA, 32'h11112222);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Second contention after data was served last
        applyStimulus(1, 32'h108, 1, 0, 4'hF, 32'h410, 0, 0, 0);
        applyStimulus(1, 32'h108, 1, 0, 4'hF, 32'h410, 0, 1, 32'h77778888);
        checkOutput("cont2 first addr", memAddrA, firstIsData ? 32'h410 : 32'h108);
        applyStimulus(1, 32'h108, 1, 0, 4'hF, 32'h410, 0, 0, 0);
        checkBit("cont2 dmemWait c2", dmemWaitA, ~firstIsData);
        checkBit("cont2 imemWait c2", imemWaitA, firstIsData);
        if (firstIsData)
            applyStimulus(1, 32'h108, 0, 0, 0, 0, 0, 1, 32'h9999AAAA);
        else
            applyStimulus(0, 0, 1, 0, 4'hF, 32'h410, 0, 1, 32'h9999AAAA);
        checkBit("cont2 memReq c3", memReqA, 1'b1);
        checkOutput("cont2 second addr", memAddrA, firstIsData ? 32'h108 : 32'h410);
        if (firstIsData)
            applyStimulus(1, 32'h108, 0, 0, 0, 0, 0, 0, 0);
        else
            applyStimulus(0, 0, 1, 0, 4'hF, 32'h410, 0, 0, 0);
        checkOutput("cont2 dmemRdata", dmemRdataA, firstIsData ? 32'h77778888 : 32'h9999AAAA);
        checkOutput("cont2 imemRdata", imemRdataA, firstIsData ? 32'h9999AAAA : 32'h77778888);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset asserted while a data write is in BUSY_D
        applyStimulus(0, 0, 1, 1, 4'hC, 32'h600, 32'hA5A5A5A5, 0, 0);
        checkBit("rstmid dmemWait c0", dmemWaitA, 1'b1);
        applyStimulus(0, 0, 1, 1, 4'hC, 32'h600, 32'hA5A5A5A5, 0, 0);
        checkBit("rstmid memReq busy", memReqA, 1'b1);
        checkOutput("rstmid memBe busy", 32'(memBeA), 32'hC);
        #2;
        rst = 1'b1;
        #1;
        checkBit("rstmid memReq", memReqA, 1'b0);
        checkBit("rstmid memWe", memWeA, 1'b0);
        checkOutput("rstmid memAddr", memAddrA, 32'h0);
        checkOutput("rstmid memWdata", memWdataA, 32'h0);
        checkOutput("rstmid memBe", 32'(memBeA), 32'h0);
        checkOutput("rstmid imemRdata", imemRdataA, 32'h0);
        checkOutput("rstmid dmemRdata", dmemRdataA, 32'h0);
        checkBit("rstmid dmemWait", dmemWaitA, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkBit("rstmid idle memReq", memReqA, 1'b0);
        checkBit("rstmid idle dmemWait", dmemWaitA, 1'b1);
        applyStimulus(0, 0, 1, 1, 4'hC, 32'h600, 32'hA5A5A5A5, 1, 32'h0);
        checkBit("rstmid regrant memReq", memReqA, 1'b1);
        checkOutput("rstmid regrant memAddr", memAddrA, 32'h600);
        checkBit("rstmid regrant memWe", memWeA, 1'b1);
        checkOutput("rstmid regrant memWdata", memWdataA, 32'hA5A5A5A5);
        applyStimulus(0, 0, 1, 1, 4'hC, 32'h600, 32'hA5A5A5A5, 0, 0);
        checkBit("rstmid done dmemWait", dmemWaitA, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Watchdog abort on instance A with TIMEOUT = 4, then a late ack and a normal fetch
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h700, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 1, 0, 4'hF, 32'h700, 0, 0, 0);
            checkBit("wd memReq busy", memReqA, 1'b1);
            checkBit("wd timeoutErr busy", timeoutErrA, 1'b0);
            checkBit("wd dmemWait busy", dmemWaitA, 1'b1);
        end
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h700, 0, 1, 32'h12121212);
        checkBit("wd memReq abort", memReqA, 1'b0);
        checkBit("wd timeoutErr abort", timeoutErrA, 1'b1);
        checkBit("wd dmemWait abort", dmemWaitA, 1'b0);
        checkOutput("wd dmemRdata abort", dmemRdataA, 32'hFFFFFFFF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h12121212);
        checkOutput("wd late ack ignored", dmemRdataA, 32'hFFFFFFFF);
        checkBit("wd late ack memReq", memReqA, 1'b0);
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        checkBit("wd next imemWait c0", imemWaitA, 1'b1);
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h0000ABCD);
        checkBit("wd next memReq", memReqA, 1'b1);
        checkOutput("wd next memAddr", memAddrA, 32'h200);
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        checkBit("wd next imemWait c2", imemWaitA, 1'b0);
        checkOutput("wd next imemRdata", imemRdataA, 32'h0000ABCD);
        checkBit("wd timeoutErr sticky", timeoutErrA, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
